// File: rtl/reduction_tree_arb_pkg.sv
// rtl/reduction_tree_arb_pkg.sv - shared types and helpers for reduction_tree_arbiter
//
// Purpose: FSM state encoding, the {valid, id} tag carried alongside each
// tree operation, and the tree-latency helper used to size the tag pipe.
// Ports: none (package).
// Optional feature macro used by the top: REDTREE_ARB_STATS_EN.

package reduction_tree_arb_pkg;

    // Widest requester ID a tag can carry; the top uses the low IDW bits.
    localparam int TAG_IDW = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    // Pipeline depth of a binary reduction tree over reduction_size elements.
    function automatic int calc_tree_lat(input int reduction_size);
        return (reduction_size == 1) ? 1 : $clog2(reduction_size);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with explicit pointer
//
// Purpose: picks the first asserted request at or after ptr (wrapping) and
// reports the pointer value that follows the winner.
// Ports:
//   req      in   NUM_REQ  request vector
//   en       in   1        grant enable; no grant when low
//   ptr      in   IDW      current round-robin start position
//   gnt      out  NUM_REQ  one-hot grant or zero
//   ptr_next out  IDW      (winner+1) mod NUM_REQ, or ptr when nothing granted

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     ptr_next
);

    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        logic           found;
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDW'(idx);
            if (en && !found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
                ptr_next = (idx == NUM_REQ - 1) ? '0 : IDW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/reduction_tree_arbiter.sv
// rtl/reduction_tree_arbiter.sv - round-robin sharing of one fixed-latency reduction tree
//
// Purpose: grants one requester per cycle onto a shared pipelined reduction
// tree, tracks each operation's owner in a tag pipe matched to the tree
// latency, returns tagged results, supports flush/drain and flags any
// tag/tree misalignment (sticky).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req_valid / o_req_ready   per-requester handshake (ready is one-hot grant)
//   i_req_data                  operands [NUM_REQ][REDUCTION_SIZE][LANES]
//   o_tree_valid / o_tree_data  registered operands to the tree
//   i_tree_valid / i_tree_data  tree result
//   o_res_valid/o_res_data/o_res_id  tagged result strobe
//   i_flush / o_flush_done      drain request / one-cycle drained pulse
//   o_busy                      any operation in flight
//   o_err                       sticky misalignment flag
//   o_grant_cnt                 per-requester grant counters (REDTREE_ARB_STATS_EN only)
// Optional macro: REDTREE_ARB_STATS_EN.

module reduction_tree_arbiter
    import reduction_tree_arb_pkg::*;
#(
    parameter int DATAW          = 18,
    parameter int LANES          = 1,
    parameter int REDUCTION_SIZE = 40,
    parameter int NUM_REQ        = 4,
    parameter int TREE_LAT       = calc_tree_lat(REDUCTION_SIZE),
    parameter int RESW           = DATAW + $clog2(REDUCTION_SIZE),
    parameter int IDW            = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic signed [DATAW-1:0] i_req_data [NUM_REQ][REDUCTION_SIZE][LANES],
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic signed [DATAW-1:0] o_tree_data [REDUCTION_SIZE][LANES],
    output logic                    o_tree_valid,
    input  logic signed [RESW-1:0]  i_tree_data [LANES],
    input  logic                    i_tree_valid,
    output logic signed [RESW-1:0]  o_res_data [LANES],
    output logic [IDW-1:0]          o_res_id,
    output logic                    o_res_valid,
    input  logic                    i_flush,
    output logic                    o_flush_done,
    output logic                    o_busy,
    output logic                    o_err
`ifdef REDTREE_ARB_STATS_EN
    ,
    output logic [31:0]             o_grant_cnt [NUM_REQ]
`endif
);

    arb_state_e              state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      gnt;
    logic                    grant_en;
    logic                    accept;
    logic [IDW-1:0]          gnt_id;

    logic                    tree_valid_q, tree_valid_d;
    logic [IDW-1:0]          tree_id_q, tree_id_d;
    logic signed [DATAW-1:0] tree_data_q [REDUCTION_SIZE][LANES];
    logic signed [DATAW-1:0] tree_data_d [REDUCTION_SIZE][LANES];

    tag_t                    tag_q [TREE_LAT];
    tag_t                    tag_d [TREE_LAT];
    tag_t                    tag_out;
    logic [TAG_IDW-1:0]      unused_tag_id;

    logic                    res_valid_q, res_valid_d;
    logic [IDW-1:0]          res_id_q, res_id_d;
    logic signed [RESW-1:0]  res_data_q [LANES];
    logic signed [RESW-1:0]  res_data_d [LANES];

    logic                    err_q, err_d;
    logic                    busy;

    // Gating with rst keeps o_req_ready low for the whole reset window.
    assign grant_en = (state_q == RUN) && !i_flush && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req      (i_req_valid),
        .en       (grant_en),
        .ptr      (ptr_q),
        .gnt      (gnt),
        .ptr_next (ptr_d)
    );

    assign accept = |gnt;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
            end
        end
    end

    // Tag pipe stage 0 is fed from the registered tree input, so the last
    // stage lines up with the cycle the tree result is due.
    assign tag_out       = tag_q[TREE_LAT-1];
    assign unused_tag_id = tag_out.id;

    always_comb begin
        tree_valid_d = accept;
        tree_id_d    = tree_id_q;
        tree_data_d  = tree_data_q;
        if (accept) begin
            tree_id_d   = gnt_id;
            tree_data_d = i_req_data[gnt_id];
        end

        tag_d[0].valid = tree_valid_q;
        tag_d[0].id    = TAG_IDW'(tree_id_q);
        for (int s = 1; s < TREE_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        // Only a result that meets its tag is emitted; either orphan is dropped.
        res_valid_d = tag_out.valid && i_tree_valid;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (res_valid_d) begin
            res_id_d   = tag_out.id[IDW-1:0];
            res_data_d = i_tree_data;
        end

        err_d = err_q | (tag_out.valid != i_tree_valid);
    end

    always_comb begin
        busy = tree_valid_q | res_valid_q;
        for (int s = 0; s < TREE_LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (i_flush) state_d = DRAIN;
            DRAIN:   if (!busy)   state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            ptr_q        <= '0;
            tree_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            for (int s = 0; s < TREE_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tree_valid_q <= tree_valid_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
            for (int s = 0; s < TREE_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        tree_id_q   <= tree_id_d;
        tree_data_q <= tree_data_d;
        res_id_q    <= res_id_d;
        res_data_q  <= res_data_d;
    end

    assign o_req_ready  = gnt;
    assign o_tree_valid = tree_valid_q;
    assign o_tree_data  = tree_data_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_id     = res_id_q;
    assign o_res_data   = res_data_q;
    assign o_flush_done = (state_q == DONE);
    assign o_busy       = busy;
    assign o_err        = err_q;

`ifdef REDTREE_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
        end
        if (state_d == DONE && state_q != DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && grant_cnt_q[i] != 32'hFFFF_FFFF) begin
                    grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    assign o_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_reduction_tree_arbiter.sv
// tb/tb_reduction_tree_arbiter.sv - self-checking bench for reduction_tree_arbiter

module tb_reduction_tree_arbiter;

    localparam int NR = 3;
    localparam int RS = 40;
    localparam int LN = 1;
    localparam int DW = 8;
    localparam int TL = 6;
    localparam int RW = DW + $clog2(RS);
    localparam int IW = $clog2(NR);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        i_req_valid;
    logic signed [DW-1:0] i_req_data [NR][RS][LN];
    logic [NR-1:0]        o_req_ready;
    logic signed [DW-1:0] o_tree_data [RS][LN];
    logic                 o_tree_valid;
    logic signed [RW-1:0] i_tree_data [LN];
    logic                 i_tree_valid;
    logic signed [RW-1:0] o_res_data [LN];
    logic [IW-1:0]        o_res_id;
    logic                 o_res_valid;
    logic                 i_flush;
    logic                 o_flush_done;
    logic                 o_busy;
    logic                 o_err;
`ifdef REDTREE_ARB_STATS_EN
    logic [31:0]          o_grant_cnt [NR];
`endif

    reduction_tree_arbiter #(
        .DATAW(DW), .LANES(LN), .REDUCTION_SIZE(RS), .NUM_REQ(NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .o_tree_data  (o_tree_data),
        .o_tree_valid (o_tree_valid),
        .i_tree_data  (i_tree_data),
        .i_tree_valid (i_tree_valid),
        .o_res_data   (o_res_data),
        .o_res_id     (o_res_id),
        .o_res_valid  (o_res_valid),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
`ifdef REDTREE_ARB_STATS_EN
        ,
        .o_grant_cnt  (o_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {int due; int sum;} tree_t;
    typedef struct {int cyc; int id; int sum;} res_t;
    tree_t tree_q[$];
    res_t  exp_q[$];
    res_t  got_q[$];
    bit    delay_next = 1'b0;
    int    m_ptr = 0;

    // Behavioural tree: sums the operands seen in cycle c, presents the result in cycle c+TL.
    initial begin
        int s;
        i_tree_valid = 1'b0;
        i_tree_data[0] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tree_q.delete();
                i_tree_valid = 1'b0;
            end else begin
                if (o_tree_valid === 1'b1) begin
                    s = 0;
                    for (int e = 0; e < RS; e++) s += int'(o_tree_data[e][0]);
                    tree_q.push_back('{cyc + TL + (delay_next ? 1 : 0), s});
                    delay_next = 1'b0;
                end
                i_tree_valid = 1'b0;
                if (tree_q.size() > 0 && tree_q[0].due == cyc) begin
                    i_tree_valid = 1'b1;
                    i_tree_data[0] = RW'(tree_q[0].sum);
                    void'(tree_q.pop_front());
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_res_valid === 1'b1)
            got_q.push_back('{cyc, int'(o_res_id), int'(o_res_data[0])});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus; the round-robin reference decides the expected grant.
    task automatic drive(input logic [NR-1:0] v, input logic fl, input logic gon,
                         output logic [NR-1:0] eg, output logic [NR-1:0] gg,
                         output logic b, output logic fd);
        int pick;
        int s;
        i_req_valid = v;
        i_flush     = fl;
        eg   = '0;
        pick = -1;
        if (gon && !fl) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (pick < 0 && v[k]) pick = k;
            end
        end
        if (pick >= 0) begin
            eg[pick] = 1'b1;
            m_ptr = (pick + 1) % NR;
            s = 0;
            for (int e = 0; e < RS; e++) s += int'(i_req_data[pick][e][0]);
            exp_q.push_back('{cyc + 2 + TL, pick, s});
        end
        @(negedge clk);
        gg = o_req_ready;
        b  = o_busy;
        fd = o_flush_done;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req_valid = '0;
        i_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic fill_data(input int mode);
        for (int r = 0; r < NR; r++)
            for (int e = 0; e < RS; e++)
                i_req_data[r][e][0] = (mode == 0) ? DW'($urandom) : DW'(mode);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req_valid = '0;
        i_flush = 1'b0;
        fill_data(0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_tree_valid !== 1'b0) begin errors++; $display("FAIL reset_tree_valid: got %b want 0", o_tree_valid); end
        checks++; if (o_res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", o_res_valid); end
        checks++; if (o_flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", o_flush_done); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        int t;
        fill_data(0);
        for (int e = 0; e < RS; e++) i_req_data[1][e][0] = 8'sd1;
        t = cyc;
        drive(3'b010, 0, 1, eg, gg, b, fd);
        checks++; if (gg !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", gg); end
        checks++; if (o_tree_valid !== 1'b1) begin errors++; $display("FAIL single_tree_valid: got %b want 1", o_tree_valid); end
        checks++; if (o_tree_data[0][0] !== 8'sd1 || o_tree_data[RS-1][0] !== 8'sd1) begin
            errors++; $display("FAIL single_tree_data: got %0d/%0d want 1/1", o_tree_data[0][0], o_tree_data[RS-1][0]); end
        repeat (12) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0].cyc != t + 8 || got_q[0].id != 1 || got_q[0].sum != 40) begin
                errors++; $display("FAIL single_result: got cyc %0d id %0d data %0d want cyc %0d id 1 data 40",
                                   got_q[0].cyc - t, got_q[0].id, got_q[0].sum, 8); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        int t;
        do_reset();
        fill_data(-128);
        t = cyc;
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 0, 1, eg, gg, b, fd);
            checks++; if (gg !== eg || eg !== NR'(1 << (k % 3))) begin
                errors++; $display("FAIL b2b_grant%0d: got %b want %b", k, gg, eg); end
        end
        repeat (12) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (got_q[k].id != k % 3 || got_q[k].sum != -5120 || got_q[k].cyc != t + 8 + k) begin
                    errors++; $display("FAIL b2b_result%0d: got id %0d data %0d cyc %0d want id %0d data -5120 cyc %0d",
                                       k, got_q[k].id, got_q[k].sum, got_q[k].cyc - t, k % 3, 8 + k); end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        int bad = 0;
        for (int n = 0; n < 150; n++) begin
            fill_data(0);
            drive(NR'($urandom_range(0, 7)), 0, 1, eg, gg, b, fd);
            if (gg !== eg) begin
                bad++;
                if (bad < 5) $display("FAIL random_grant: cycle %0d got %b want %b", n, gg, eg);
            end
        end
        checks++; if (bad != 0) errors++;
        repeat (12) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            bad = 0;
            foreach (exp_q[k]) begin
                if (got_q[k].cyc != exp_q[k].cyc || got_q[k].id != exp_q[k].id || got_q[k].sum != exp_q[k].sum) begin
                    bad++;
                    if (bad < 5) $display("FAIL random_result%0d: got id %0d data %0d cyc %0d want id %0d data %0d cyc %0d",
                                          k, got_q[k].id, got_q[k].sum, got_q[k].cyc, exp_q[k].id, exp_q[k].sum, exp_q[k].cyc);
                end
            end
            checks++; if (bad != 0) errors++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_flush();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        int n = 0, c0, busy_fall = -1, done_cyc = -1, done_cnt = 0, bad = 0;
        fill_data(0);
        repeat (4) drive(3'b111, 0, 1, eg, gg, b, fd);
        drive(3'b111, 1, 1, eg, gg, b, fd);
        checks++; if (gg !== 3'b000) begin errors++; $display("FAIL flush_cycle_grant: got %b want 000", gg); end
        while (done_cnt == 0 && n < 40) begin
            c0 = cyc;
            drive(3'b111, (n == 1), 0, eg, gg, b, fd);
            if (gg !== 3'b000) bad++;
            if (!b && busy_fall < 0) busy_fall = c0;
            if (fd) begin done_cnt++; done_cyc = c0; end
            n++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL flush_drain_grants: got %0d grants want 0", bad); end
        checks++; if (done_cnt != 1 || busy_fall < 0 || done_cyc != busy_fall + 1) begin
            errors++; $display("FAIL flush_done_timing: got done %0d at %0d busy fell %0d want done 1 cycle after", done_cnt, done_cyc, busy_fall); end
        drive(3'b111, 0, 1, eg, gg, b, fd);
        checks++; if (gg !== eg || gg === 3'b000) begin errors++; $display("FAIL flush_resume: got %b want %b", gg, eg); end
        for (int k = 0; k < 14; k++) begin
            drive('0, 0, 1, eg, gg, b, fd);
            if (fd) done_cnt++;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL flush_done_once: got %0d want 1", done_cnt); end
        checks++; if (got_q.size() != 5 || exp_q.size() != 5) begin
            errors++; $display("FAIL flush_results: got %0d want 5", got_q.size()); end
        else begin
            bad = 0;
            foreach (exp_q[k])
                if (got_q[k].cyc != exp_q[k].cyc || got_q[k].id != exp_q[k].id || got_q[k].sum != exp_q[k].sum) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL flush_result_values: got %0d wrong want 0", bad); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_misalign();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        do_reset();
        fill_data(0);
        delay_next = 1'b1;
        drive(3'b001, 0, 1, eg, gg, b, fd);
        repeat (12) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", o_err); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL misalign_emitted: got %0d want 0", got_q.size()); end
        repeat (5) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", o_err); end
        do_reset();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", o_err); end
    endtask

    task automatic test_async_reset();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        do_reset();
        fill_data(0);
        repeat (3) drive(3'b111, 0, 1, eg, gg, b, fd);
        i_req_valid = 3'b111;
        #2 rst = 1'b1;
        #1;
        checks++; if ({o_tree_valid, o_res_valid, o_busy, o_err, o_flush_done} !== 5'b0 || o_req_ready !== 3'b000) begin
            errors++; $display("FAIL async_rst_outputs: got tv%b rv%b busy%b err%b fd%b rdy%b want all 0",
                               o_tree_valid, o_res_valid, o_busy, o_err, o_flush_done, o_req_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        got_q.delete();
        repeat (12) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL async_rst_stale: got %0d want 0", got_q.size()); end
        drive(3'b111, 0, 1, eg, gg, b, fd);
        checks++; if (gg !== 3'b001 || eg !== 3'b001) begin errors++; $display("FAIL async_rst_ptr: got %b want 001", gg); end
        repeat (10) drive('0, 0, 1, eg, gg, b, fd);
        checks++; if (got_q.size() != 1 || got_q[0].id != 0 || got_q[0].sum != exp_q[0].sum) begin
            errors++; $display("FAIL async_rst_result: got %0d results want 1 for id 0", got_q.size()); end
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef REDTREE_ARB_STATS_EN
    task automatic test_stats();
        logic [NR-1:0] eg, gg;
        logic b, fd;
        int n = 0;
        do_reset();
        fill_data(0);
        repeat (5) drive(3'b100, 0, 1, eg, gg, b, fd);
        checks++; if (o_grant_cnt[2] !== 32'd5 || o_grant_cnt[0] !== 32'd0) begin
            errors++; $display("FAIL stats_count: got %0d/%0d want 5/0", o_grant_cnt[2], o_grant_cnt[0]); end
        drive('0, 1, 1, eg, gg, b, fd);
        fd = 1'b0;
        while (!fd && n < 40) begin
            drive('0, 0, 0, eg, gg, b, fd);
            n++;
        end
        checks++; if (!fd || o_grant_cnt[2] !== 32'd0) begin
            errors++; $display("FAIL stats_clear: got %0d done %b want 0 done 1", o_grant_cnt[2], fd); end
        exp_q.delete();
        got_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_flush();
        test_misalign();
        test_async_reset();
`ifdef REDTREE_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
